// File: rtl/lc3b_types.sv
// Shared types for the LC-3b out-of-order core.
//
// Contents:
//   LC3B_NUM_REGS / LC3B_DATA_W / LC3B_ROB_ID_W : default machine geometry
//   LC3B_IDX_W     : register index width, one bit wider than needed so the
//                    PC can be named by index
//   PC_IDX         : PC sentinel index, first index past the architectural file
//   rename_entry_t : per-register rename state (committed value, busy, tag)
package lc3b_types;

    localparam int LC3B_NUM_REGS = 8;
    localparam int LC3B_DATA_W   = 16;
    localparam int LC3B_ROB_ID_W = 4;
    localparam int LC3B_IDX_W    = $clog2(LC3B_NUM_REGS) + 1;

    // Any index >= PC_IDX does not name an architectural register.
    localparam logic [LC3B_IDX_W-1:0] PC_IDX = LC3B_IDX_W'(LC3B_NUM_REGS);

    // tag_valid is the busy bit; the tag field carries no sentinel encoding.
    typedef struct packed {
        logic [LC3B_DATA_W-1:0]   value;
        logic                     tag_valid;
        logic [LC3B_ROB_ID_W-1:0] tag;
    } rename_entry_t;

endpackage

// File: rtl/rename_read_port.sv
// One combinational read port of the rename register file.
//
// Ports:
//   idx          : register index to read (indices >= NUM_REGS read as zero)
//   regs         : current rename state of every architectural register
//   commit_valid / commit_dest / commit_rob / commit_value : retire write in
//                  flight this cycle, used for the same-cycle bypass
//   value / busy / tag : read result
module rename_read_port
    import lc3b_types::*;
#(
    parameter int NUM_REGS = LC3B_NUM_REGS,
    parameter int DATA_W   = LC3B_DATA_W,
    parameter int ROB_ID_W = LC3B_ROB_ID_W,
    parameter int IDX_W    = $clog2(NUM_REGS) + 1
)(
    input  logic [IDX_W-1:0]    idx,
    input  rename_entry_t       regs [NUM_REGS],
    input  logic                commit_valid,
    input  logic [IDX_W-1:0]    commit_dest,
    input  logic [ROB_ID_W-1:0] commit_rob,
    input  logic [DATA_W-1:0]   commit_value,
    output logic [DATA_W-1:0]   value,
    output logic                busy,
    output logic [ROB_ID_W-1:0] tag
);

    rename_entry_t sel;
    logic          hit;
    logic          bypass;

    always_comb begin
        sel    = '0;
        hit    = 1'b0;
        bypass = 1'b0;
        value  = '0;
        busy   = 1'b0;
        tag    = '0;

        // Explicit compare mux so that out-of-range indices (including the
        // PC sentinel) never address the array.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel = regs[i];
                hit = 1'b1;
            end
        end

        if (hit) begin
            // A retiring producer whose tag is still the one recorded here
            // hands its value straight to the reader and the register reads
            // as no longer busy.
            bypass = commit_valid && (commit_dest == idx) && (sel.tag == commit_rob);
            value  = bypass ? commit_value : sel.value;
            busy   = sel.tag_valid && !bypass;
            tag    = sel.tag;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Rename-aware architectural register file with one branch checkpoint.
//
// Ports:
//   clk, rst                 : clock (rising edge), async active-high reset
//   commit_*                 : retire write of a value, clears busy on tag match
//   disp_*                   : dispatch rename, marks destination busy with a tag
//   flush                    : drop all speculative tags and the checkpoint
//   ckpt_save / ckpt_restore : capture / reinstate the busy+tag map
//   ckpt_valid               : a checkpoint is held
//   rd_idx / rd_value / rd_busy / rd_tag : NUM_RD combinational read ports
module rename_regfile
    import lc3b_types::*;
#(
    parameter int NUM_REGS  = LC3B_NUM_REGS,
    parameter int DATA_W    = LC3B_DATA_W,
    parameter int ROB_ID_W  = LC3B_ROB_ID_W,
    parameter int NUM_RD    = 2,
    localparam int IDX_W    = $clog2(NUM_REGS) + 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                commit_valid,
    input  logic [IDX_W-1:0]    commit_dest,
    input  logic [ROB_ID_W-1:0] commit_rob,
    input  logic [DATA_W-1:0]   commit_value,
    input  logic                disp_valid,
    input  logic [IDX_W-1:0]    disp_dest,
    input  logic [ROB_ID_W-1:0] disp_rob,
    input  logic                flush,
    input  logic                ckpt_save,
    input  logic                ckpt_restore,
    output logic                ckpt_valid,
    input  logic [IDX_W-1:0]    rd_idx   [NUM_RD],
    output logic [DATA_W-1:0]   rd_value [NUM_RD],
    output logic                rd_busy  [NUM_RD],
    output logic [ROB_ID_W-1:0] rd_tag   [NUM_RD]
);

    // Live state and the checkpointed busy/tag map (values are never saved).
    rename_entry_t       regs      [NUM_REGS];
    logic [NUM_REGS-1:0] ckpt_tv;
    logic [ROB_ID_W-1:0] ckpt_tag  [NUM_REGS];

    rename_entry_t       regs_nxt     [NUM_REGS];
    logic [NUM_REGS-1:0] ckpt_tv_nxt;
    logic [ROB_ID_W-1:0] ckpt_tag_nxt [NUM_REGS];
    logic                ckpt_valid_nxt;

    logic commit_ok;
    logic disp_ok;
    logic restore_act;
    logic bypass_en;

    always_comb begin
        commit_ok   = commit_valid && (commit_dest < IDX_W'(NUM_REGS));
        disp_ok     = disp_valid && (disp_dest < IDX_W'(NUM_REGS));
        restore_act = ckpt_restore && ckpt_valid;

        // Priority: flush, then restore, then save.
        ckpt_valid_nxt = ckpt_valid;
        if (flush) begin
            ckpt_valid_nxt = 1'b0;
        end else if (restore_act) begin
            ckpt_valid_nxt = 1'b0;
        end else if (ckpt_save) begin
            ckpt_valid_nxt = 1'b1;
        end

        for (int i = 0; i < NUM_REGS; i++) begin : g_next
            automatic rename_entry_t       live   = regs[i];
            automatic logic                ck_tv  = ckpt_tv[i];
            automatic logic [ROB_ID_W-1:0] ck_tag = ckpt_tag[i];
            automatic logic                commit_hit = commit_ok && (commit_dest == IDX_W'(i));
            automatic logic                disp_hit   = disp_ok && (disp_dest == IDX_W'(i));

            // The retire write always lands; busy clears only if this
            // register still waits on the retiring ROB entry.
            if (commit_hit) begin
                live.value = commit_value;
                if (regs[i].tag == commit_rob) begin
                    live.tag_valid = 1'b0;
                end
            end

            // Keep the checkpoint consistent with retirements so a restore
            // does not resurrect a busy bit whose producer already retired.
            if (commit_hit && ckpt_valid && (ckpt_tag[i] == commit_rob)) begin
                ck_tv = 1'b0;
            end

            if (flush) begin
                live.tag_valid = 1'b0;
            end else if (restore_act) begin
                live.tag_valid = ck_tv;
                live.tag       = ck_tag;
            end else begin
                if (disp_hit) begin
                    live.tag_valid = 1'b1;
                    live.tag       = disp_rob;
                end
                // Snapshot is taken after this cycle's commit and dispatch.
                if (ckpt_save) begin
                    ck_tv  = live.tag_valid;
                    ck_tag = live.tag;
                end
            end

            regs_nxt[i]     = live;
            ckpt_tv_nxt[i]  = ck_tv;
            ckpt_tag_nxt[i] = ck_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]     <= '0;
                ckpt_tag[i] <= '0;
            end
            ckpt_tv    <= '0;
            ckpt_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]     <= regs_nxt[i];
                ckpt_tag[i] <= ckpt_tag_nxt[i];
            end
            ckpt_tv    <= ckpt_tv_nxt;
            ckpt_valid <= ckpt_valid_nxt;
        end
    end

    // State is already zero under reset, but the bypass would still forward
    // commit_value (all tags are 0 and may match); gate it so reads are zero.
    assign bypass_en = commit_valid && !rst;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        rename_read_port #(
            .NUM_REGS (NUM_REGS),
            .DATA_W   (DATA_W),
            .ROB_ID_W (ROB_ID_W),
            .IDX_W    (IDX_W)
        ) u_rd (
            .idx          (rd_idx[g]),
            .regs         (regs),
            .commit_valid (bypass_en),
            .commit_dest  (commit_dest),
            .commit_rob   (commit_rob),
            .commit_value (commit_value),
            .value        (rd_value[g]),
            .busy         (rd_busy[g]),
            .tag          (rd_tag[g])
        );
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// register file kept as plain arrays.
module tb_rename_regfile;

    localparam int NR = 8;
    localparam int NP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [3:0]  commit_dest;
    logic [3:0]  commit_rob;
    logic [15:0] commit_value;
    logic        disp_valid;
    logic [3:0]  disp_dest;
    logic [3:0]  disp_rob;
    logic        flush;
    logic        ckpt_save;
    logic        ckpt_restore;
    logic        ckpt_valid;
    logic [3:0]  rd_idx   [NP];
    logic [15:0] rd_value [NP];
    logic        rd_busy  [NP];
    logic [3:0]  rd_tag   [NP];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [15:0] m_val  [NR];
    bit          m_tv   [NR];
    logic [3:0]  m_tag  [NR];
    bit          m_ctv  [NR];
    logic [3:0]  m_ctag [NR];
    bit          m_ckv;

    rename_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_dest  (commit_dest),
        .commit_rob   (commit_rob),
        .commit_value (commit_value),
        .disp_valid   (disp_valid),
        .disp_dest    (disp_dest),
        .disp_rob     (disp_rob),
        .flush        (flush),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .ckpt_valid   (ckpt_valid),
        .rd_idx       (rd_idx),
        .rd_value     (rd_value),
        .rd_busy      (rd_busy),
        .rd_tag       (rd_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_val[i] = '0; m_tv[i] = 0; m_tag[i] = '0;
            m_ctv[i] = 0;  m_ctag[i] = '0;
        end
        m_ckv = 0;
    endtask

    // Apply one clock edge's worth of behaviour: retire, then the
    // flush / restore / dispatch+save choice.
    task automatic model_step();
        int  cd;
        int  dd;
        bit  rest;
        cd   = int'(commit_dest);
        dd   = int'(disp_dest);
        rest = ckpt_restore && m_ckv;
        if (commit_valid && cd < NR) begin
            m_val[cd] = commit_value;
            if (m_tag[cd] == commit_rob) m_tv[cd] = 0;
            if (m_ckv && m_ctag[cd] == commit_rob) m_ctv[cd] = 0;
        end
        if (flush) begin
            for (int i = 0; i < NR; i++) m_tv[i] = 0;
            m_ckv = 0;
        end else if (rest) begin
            for (int i = 0; i < NR; i++) begin
                m_tv[i]  = m_ctv[i];
                m_tag[i] = m_ctag[i];
            end
            m_ckv = 0;
        end else begin
            if (disp_valid && dd < NR) begin
                m_tv[dd]  = 1;
                m_tag[dd] = disp_rob;
            end
            if (ckpt_save) begin
                for (int i = 0; i < NR; i++) begin
                    m_ctv[i]  = m_tv[i];
                    m_ctag[i] = m_tag[i];
                end
                m_ckv = 1;
            end
        end
    endtask

    task automatic idle();
        commit_valid = 0; commit_dest = '0; commit_rob = '0; commit_value = '0;
        disp_valid   = 0; disp_dest   = '0; disp_rob   = '0;
        flush = 0; ckpt_save = 0; ckpt_restore = 0;
    endtask

    // One clock edge; returns 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic check_outputs(input string ctx);
        int          i;
        bit          byp;
        logic [15:0] ev;
        logic        eb;
        logic [3:0]  et;
        for (int p = 0; p < NP; p++) begin
            i  = int'(rd_idx[p]);
            ev = '0; eb = 0; et = '0;
            if (i < NR) begin
                byp = commit_valid && (int'(commit_dest) == i) && (m_tag[i] == commit_rob);
                ev  = byp ? commit_value : m_val[i];
                eb  = m_tv[i] && !byp;
                et  = m_tag[i];
            end
            check_eq($sformatf("%s rd_value[%0d] idx%0d", ctx, p, i), 32'(rd_value[p]), 32'(ev));
            check_eq($sformatf("%s rd_busy[%0d] idx%0d", ctx, p, i), 32'(rd_busy[p]), 32'(eb));
            check_eq($sformatf("%s rd_tag[%0d] idx%0d", ctx, p, i), 32'(rd_tag[p]), 32'(et));
        end
        check_eq({ctx, " ckpt_valid"}, 32'(ckpt_valid), 32'(m_ckv));
    endtask

    // Directed read of one register through port 1 with no commit in flight.
    task automatic expect_reg(input string ctx, input int idx, input logic [15:0] v,
                              input logic b, input logic [3:0] t);
        rd_idx[1] = 4'(idx);
        #1;
        check_eq({ctx, " value"}, 32'(rd_value[1]), 32'(v));
        check_eq({ctx, " busy"},  32'(rd_busy[1]),  32'(b));
        check_eq({ctx, " tag"},   32'(rd_tag[1]),   32'(t));
    endtask

    task automatic check_all_regs(input string ctx);
        for (int i = 0; i < NR; i++) begin
            rd_idx[0] = 4'(i);
            rd_idx[1] = 4'((i + 3) % 10);
            #1;
            check_outputs($sformatf("%s r%0d", ctx, i));
        end
    endtask

    task automatic randomize_inputs();
        commit_valid = ($urandom_range(0, 2) != 0);
        commit_dest  = 4'($urandom_range(0, 9));
        commit_rob   = 4'($urandom_range(0, 3));
        commit_value = 16'($urandom);
        disp_valid   = ($urandom_range(0, 2) != 0);
        disp_dest    = 4'($urandom_range(0, 9));
        disp_rob     = 4'($urandom_range(0, 3));
        flush        = ($urandom_range(0, 15) == 0);
        ckpt_save    = ($urandom_range(0, 7) == 0);
        ckpt_restore = ($urandom_range(0, 7) == 0);
        rd_idx[0]    = 4'($urandom_range(0, 11));
        rd_idx[1]    = (commit_valid && $urandom_range(0, 1) == 1) ? commit_dest
                                                                   : 4'($urandom_range(0, 11));
    endtask

    initial begin
        // Reset with a live commit to confirm reads stay at zero.
        rst = 1;
        idle();
        model_reset();
        commit_valid = 1; commit_dest = 4'd0; commit_rob = 4'd0; commit_value = 16'hFFFF;
        rd_idx[0] = 4'd0; rd_idx[1] = 4'd5;
        #2;
        check_eq("reset rd_value0", 32'(rd_value[0]), 32'h0);
        check_eq("reset rd_busy0",  32'(rd_busy[0]),  32'h0);
        check_eq("reset ckpt_valid", 32'(ckpt_valid), 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 0;
        idle();
        tick();

        // Dispatch then matching commit.
        disp_valid = 1; disp_dest = 4'd3; disp_rob = 4'd5;
        tick(); idle();
        expect_reg("disp r3", 3, 16'h0, 1'b1, 4'd5);
        commit_valid = 1; commit_dest = 4'd3; commit_rob = 4'd5; commit_value = 16'h1234;
        tick(); idle();
        expect_reg("commit r3", 3, 16'h1234, 1'b0, 4'd5);

        // Stale commit does not clear a newer rename.
        disp_valid = 1; disp_dest = 4'd3; disp_rob = 4'd5; tick();
        disp_rob = 4'd9; tick(); idle();
        commit_valid = 1; commit_dest = 4'd3; commit_rob = 4'd5; commit_value = 16'hAAAA;
        tick(); idle();
        expect_reg("stale commit r3", 3, 16'hAAAA, 1'b1, 4'd9);

        // Same-cycle commit and dispatch, with bypass read.
        disp_valid = 1; disp_dest = 4'd2; disp_rob = 4'd1;
        tick(); idle();
        commit_valid = 1; commit_dest = 4'd2; commit_rob = 4'd1; commit_value = 16'd7;
        disp_valid = 1; disp_dest = 4'd2; disp_rob = 4'd4;
        rd_idx[0] = 4'd2;
        #1;
        check_eq("bypass r2 value", 32'(rd_value[0]), 32'd7);
        check_eq("bypass r2 busy",  32'(rd_busy[0]),  32'd0);
        tick(); idle();
        expect_reg("commit+disp r2", 2, 16'd7, 1'b1, 4'd4);

        // Checkpoint save / retire / restore.
        disp_valid = 1; disp_dest = 4'd1; disp_rob = 4'd2; tick(); idle();
        ckpt_save = 1; tick(); idle();
        check_eq("save ckpt_valid", 32'(ckpt_valid), 32'd1);
        disp_valid = 1; disp_dest = 4'd4; disp_rob = 4'd3; tick(); idle();
        commit_valid = 1; commit_dest = 4'd1; commit_rob = 4'd2; commit_value = 16'h0011;
        tick(); idle();
        ckpt_restore = 1; tick(); idle();
        expect_reg("restore r1", 1, 16'h0011, 1'b0, 4'd2);
        expect_reg("restore r4", 4, 16'h0000, 1'b0, 4'd0);
        check_eq("restore ckpt_valid", 32'(ckpt_valid), 32'd0);

        // Flush with same-cycle commit and dropped dispatch / save.
        for (int i = 0; i < NR; i++) begin
            disp_valid = 1; disp_dest = 4'(i); disp_rob = 4'(i); tick();
        end
        idle();
        ckpt_save = 1; tick(); idle();
        flush = 1; ckpt_save = 1;
        commit_valid = 1; commit_dest = 4'd7; commit_rob = 4'd7; commit_value = 16'hBEEF;
        disp_valid = 1; disp_dest = 4'd0; disp_rob = 4'd1;
        tick(); idle();
        expect_reg("flush r7", 7, 16'hBEEF, 1'b0, 4'd7);
        expect_reg("flush r0", 0, 16'h0000, 1'b0, 4'd0);
        check_eq("flush ckpt_valid", 32'(ckpt_valid), 32'd0);
        check_all_regs("after flush");

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            randomize_inputs();
            #1;
            check_outputs($sformatf("rand c%0d", c));
            tick();
        end
        idle();

        // Reset asserted between edges while a commit is pending.
        commit_valid = 1; commit_dest = 4'd6; commit_rob = m_tag[6]; commit_value = 16'h7777;
        rd_idx[0] = 4'd6; rd_idx[1] = 4'd2;
        #2 rst = 1;
        #1;
        model_reset();
        for (int p = 0; p < NP; p++) begin
            check_eq($sformatf("midreset rd_value[%0d]", p), 32'(rd_value[p]), 32'h0);
            check_eq($sformatf("midreset rd_busy[%0d]", p),  32'(rd_busy[p]),  32'h0);
            check_eq($sformatf("midreset rd_tag[%0d]", p),   32'(rd_tag[p]),   32'h0);
        end
        check_eq("midreset ckpt_valid", 32'(ckpt_valid), 32'h0);
        tick();
        #2 rst = 0;
        idle();
        check_all_regs("post reset");

        // Out-of-range destinations are ignored.
        commit_valid = 1; commit_dest = 4'd8; commit_rob = 4'd0; commit_value = 16'h5555;
        disp_valid = 1; disp_dest = 4'd9; disp_rob = 4'd3;
        tick(); idle();
        check_all_regs("oob dest");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of architectural registers.
REQ-002 SHALL have parameter DATA_W, default 16, register value width.
REQ-003 SHALL have parameter ROB_ID_W, default 4, reorder-buffer tag width.
REQ-004 SHALL have parameter NUM_RD, default 2, number of read ports; IDX_W = $clog2(NUM_REGS)+1, and indices >= NUM_REGS (PC sentinel) are out of range.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports commit_valid/commit_dest/commit_rob/commit_value  input  1/IDX_W/ROB_ID_W/DATA_W  retire write.
REQ-008 SHALL have ports disp_valid/disp_dest/disp_rob  input  1/IDX_W/ROB_ID_W  rename of destination at dispatch.
REQ-009 SHALL have port flush  input  1  discard all speculative tags.
REQ-010 SHALL have ports ckpt_save/ckpt_restore  input  1/1  branch checkpoint control; ckpt_valid  output  1  checkpoint held.
REQ-011 SHALL have ports rd_idx[NUM_RD]  input  IDX_W; rd_value[NUM_RD]  output  DATA_W; rd_busy[NUM_RD]  output  1; rd_tag[NUM_RD]  output  ROB_ID_W.

Function
REQ-012 SHALL hold per register: value, tag_valid, tag; busy is tag_valid, with no sentinel tag encoding.
REQ-013 SHALL on commit_valid with in-range dest write commit_value at the next edge, clearing tag_valid only if the stored tag equals commit_rob.
REQ-014 SHALL on disp_valid with in-range dest set tag_valid=1, tag=disp_rob at the next edge.
REQ-015 SHALL, on same-cycle commit and dispatch to one register, write the value and leave tag_valid=1, tag=disp_rob.
REQ-016 SHALL ignore any commit or dispatch with an out-of-range dest entirely.
REQ-017 SHALL on flush clear tag_valid of all NUM_REGS registers and clear ckpt_valid; a same-cycle commit value is still written, and a same-cycle dispatch and save are dropped.
REQ-018 SHALL on ckpt_save capture all tag_valid/tag as they will be after this cycle's commit/dispatch, set ckpt_valid, and overwrite any held checkpoint.
REQ-019 SHALL, while ckpt_valid, apply each commit's tag-match clear to the checkpoint copy as well.
REQ-020 SHALL on ckpt_restore with ckpt_valid load live tags from the checkpoint, including any same-cycle commit clear, drop a same-cycle dispatch, and clear ckpt_valid; a restore without ckpt_valid is ignored.
REQ-021 SHALL resolve priorities as flush > restore > save; register values are never checkpointed.
REQ-022 SHALL provide combinational reads with zero latency and commit bypass: if rd_idx == commit_dest, commit_valid, and the stored tag matches, then rd_value = commit_value and rd_busy = 0.
REQ-023 SHALL return rd_value=0, rd_busy=0, rd_tag=0 for an out-of-range rd_idx.

Reset
REQ-024 SHALL on rst asynchronously set all values to 0, all tag_valid and tag to 0, checkpoint contents to 0, and ckpt_valid to 0.
REQ-025 SHALL, as a consequence, drive rd_busy=0 and rd_value=0 on every port during reset.
REQ-026 SHALL take reset mid-operation over all inputs, with no state change until the first edge after deassertion.

Structure
REQ-027 SHALL place the rename entry struct (value, tag_valid, tag) and the PC sentinel index constant in lc3b_types.
REQ-028 SHALL implement a sub-module rename_read_port (index decode, range check, commit bypass), instantiated NUM_RD times by generate.

Verification
REQ-029 SHALL cover: disp R3 rob 5, then commit R3 rob 5 value 0x1234 -> R3 busy=0, value 0x1234.
REQ-030 SHALL cover: disp R3 rob 5, disp R3 rob 9, commit R3 rob 5 value 0xAAAA -> value 0xAAAA, busy=1, tag=9.
REQ-031 SHALL cover: same cycle commit R2 rob 1 value 7 and disp R2 rob 4 -> value 7, busy=1, tag=4; read same cycle shows value 7, busy=0.
REQ-032 SHALL cover: disp R1 rob 2, save, disp R4 rob 3, commit R1 rob 2, restore -> R1 busy=0, R4 busy=0, ckpt_valid=0.
REQ-033 SHALL cover: busy R0..R7, flush with commit R7 rob match value 0xBEEF and disp R0 -> all busy=0, R7=0xBEEF, ckpt_valid=0.
REQ-034 SHALL cover: rst asserted mid-sequence between edges -> outputs 0 immediately; commit to dest 8 -> no change.
